// File: rtl/clk_enable_gen.sv
// clk_enable_gen: multi-channel clock-enable generator.
// Every channel divides the single system clock by a runtime-loadable
// divisor and produces a one-cycle enable strobe (ce) plus a 50% square
// wave (sq) that toggles on each strobe. Downstream logic (CPU core,
// PC/ROM stepping, LED blink) qualifies on ce instead of using derived
// clocks, so the whole design stays in a single clock domain.
//
// Divisor changes requested while a channel is counting are queued and
// take effect at that channel's next terminal count. Because of this the
// counter never sits above div-1. A sync pulse clears all counters so
// that channels with equal divisors strobe on the same edge.
module clk_enable_gen #(
    parameter int CHANNELS  = 3,
    parameter int DIV_WIDTH = 16,
    parameter int RESET_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 sync,
    input  logic [CHANNELS-1:0]  div_wr,
    input  logic [DIV_WIDTH-1:0] div_data,
    output logic [CHANNELS-1:0]  ce,
    output logic [CHANNELS-1:0]  sq,
    output logic [CHANNELS-1:0]  pending
);

    localparam logic [DIV_WIDTH-1:0] RESET_DIV_V = DIV_WIDTH'(RESET_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE_V       = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] ZERO_V      = '0;

    // Per-channel state, packed so that reset can clear whole vectors.
    logic [CHANNELS-1:0][DIV_WIDTH-1:0] div_q, div_d;
    logic [CHANNELS-1:0][DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0][DIV_WIDTH-1:0] pend_val_q, pend_val_d;
    logic [CHANNELS-1:0]                pending_q, pending_d;
    logic [CHANNELS-1:0]                ce_q, ce_d;
    logic [CHANNELS-1:0]                sq_q, sq_d;

    // Per-channel qualifiers shared by the next-state logic.
    logic [CHANNELS-1:0] counting;
    logic [CHANNELS-1:0] terminal;

    // A channel counts when globally enabled and its divisor is non-zero;
    // its terminal count is the last cycle of the current period.
    always_comb begin
        counting = '0;
        terminal = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            counting[i] = run && (div_q[i] != ZERO_V);
            terminal[i] = counting[i] && (cnt_q[i] == (div_q[i] - ONE_V));
        end
    end

    // Next-state for every channel; priority is sync, then divisor write,
    // then normal counting.
    always_comb begin
        div_d      = div_q;
        cnt_d      = cnt_q;
        pend_val_d = pend_val_q;
        pending_d  = pending_q;
        ce_d       = '0;
        sq_d       = sq_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sync) begin
                // Phase alignment: restart every channel from zero and
                // settle any divisor change right now.
                cnt_d[i] = ZERO_V;
                ce_d[i]  = 1'b0;
                sq_d[i]  = 1'b0;
                if (div_wr[i]) begin
                    div_d[i]     = div_data;
                    pending_d[i] = 1'b0;
                end else if (pending_q[i]) begin
                    div_d[i]     = pend_val_q[i];
                    pending_d[i] = 1'b0;
                end
            end else if (div_wr[i]) begin
                if (terminal[i]) begin
                    // Write lands on the terminal count: the strobe still
                    // fires and the new divisor bypasses the queue.
                    cnt_d[i]     = ZERO_V;
                    ce_d[i]      = 1'b1;
                    sq_d[i]      = ~sq_q[i];
                    div_d[i]     = div_data;
                    pending_d[i] = 1'b0;
                end else if (counting[i]) begin
                    // Mid-period write: keep counting on the old divisor
                    // and queue the new one (last write wins).
                    cnt_d[i]      = cnt_q[i] + ONE_V;
                    pend_val_d[i] = div_data;
                    pending_d[i]  = 1'b1;
                end else begin
                    // Idle channel: nothing in flight, load directly.
                    div_d[i]     = div_data;
                    cnt_d[i]     = ZERO_V;
                    pending_d[i] = 1'b0;
                    if (div_data == ZERO_V) begin
                        sq_d[i] = 1'b0;
                    end
                end
            end else if (div_q[i] == ZERO_V) begin
                // Disabled channel: outputs parked low, counter held at 0.
                cnt_d[i] = ZERO_V;
                sq_d[i]  = 1'b0;
            end else if (!run) begin
                // Paused: counter and square wave hold for a clean resume.
                cnt_d[i] = cnt_q[i];
            end else if (terminal[i]) begin
                // End of period: strobe, toggle, and apply a queued divisor.
                cnt_d[i] = ZERO_V;
                ce_d[i]  = 1'b1;
                sq_d[i]  = ~sq_q[i];
                if (pending_q[i]) begin
                    div_d[i]     = pend_val_q[i];
                    pending_d[i] = 1'b0;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + ONE_V;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q      <= {CHANNELS{RESET_DIV_V}};
            cnt_q      <= '0;
            pend_val_q <= '0;
            pending_q  <= '0;
            ce_q       <= '0;
            sq_q       <= '0;
        end else begin
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            pend_val_q <= pend_val_d;
            pending_q  <= pending_d;
            ce_q       <= ce_d;
            sq_q       <= sq_d;
        end
    end

    assign ce      = ce_q;
    assign sq      = sq_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed testbench for clk_enable_gen (3 channels, reset divisor 2).
module tb_clk_enable_gen;

    localparam int CH = 3;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          run;
    logic          sync;
    logic [CH-1:0] div_wr;
    logic [DW-1:0] div_data;
    logic [CH-1:0] ce;
    logic [CH-1:0] sq;
    logic [CH-1:0] pending;

    int checks;
    int failures;

    clk_enable_gen #(
        .CHANNELS  (CH),
        .DIV_WIDTH (DW),
        .RESET_DIV (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .sync     (sync),
        .div_wr   (div_wr),
        .div_data (div_data),
        .ce       (ce),
        .sq       (sq),
        .pending  (pending)
    );

    // Free-running system clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic r, input logic s,
                                 input logic [CH-1:0] wr, input logic [DW-1:0] data);
        run      = r;
        sync     = s;
        div_wr   = wr;
        div_data = data;
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [CH-1:0] exp_ce,
                               input logic [CH-1:0] exp_sq, input logic [CH-1:0] exp_pend);
        checks++;
        assert (ce === exp_ce) else begin
            failures++;
            $error("[TB] FAIL %s.ce observed=%b expected=%b", tag, ce, exp_ce);
        end
        checks++;
        assert (sq === exp_sq) else begin
            failures++;
            $error("[TB] FAIL %s.sq observed=%b expected=%b", tag, sq, exp_sq);
        end
        checks++;
        assert (pending === exp_pend) else begin
            failures++;
            $error("[TB] FAIL %s.pending observed=%b expected=%b", tag, pending, exp_pend);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'b000, 16'd0);

        // 1: reset state, default divisor 2 on all channels
        $display("[TB] reset release with default divisor");
        #3;
        checkOutput("reset", 3'b000, 3'b000, 3'b000);
        #9;
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 3'b000, 16'd0);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            checkOutput($sformatf("div2_e%0d", k),
                        (k % 2 == 0) ? 3'b111 : 3'b000,
                        ((k / 2) % 2 == 1) ? 3'b111 : 3'b000,
                        3'b000);
        end
        tick(1);
        checkOutput("div2_e7", 3'b000, 3'b111, 3'b000);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset", 3'b000, 3'b000, 3'b000);
        tick(1);
        checkOutput("reset_held", 3'b000, 3'b000, 3'b000);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'b000, 16'd0);

        // 2: queued divisor change on channel 0
        $display("[TB] queued divisor change");
        applyStimulus(1'b0, 1'b0, 3'b110, 16'd0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 3'b001, 16'd4);
        tick(1);
        applyStimulus(1'b1, 1'b0, 3'b000, 16'd0);
        tick(1);
        applyStimulus(1'b1, 1'b0, 3'b001, 16'd3);
        tick(1);
        checkOutput("queue3_written", 3'b000, 3'b000, 3'b001);
        applyStimulus(1'b1, 1'b0, 3'b000, 16'd0);
        tick(1);
        checkOutput("queue3_waiting", 3'b000, 3'b000, 3'b001);
        tick(1);
        checkOutput("old_period_strobe", 3'b001, 3'b001, 3'b000);
        tick(2);
        checkOutput("new_period_gap", 3'b000, 3'b001, 3'b000);
        tick(1);
        checkOutput("period3_strobe", 3'b001, 3'b000, 3'b000);
        applyStimulus(1'b1, 1'b0, 3'b001, 16'd5);
        tick(1);
        checkOutput("queue5", 3'b000, 3'b000, 3'b001);
        applyStimulus(1'b1, 1'b0, 3'b001, 16'd7);
        tick(1);
        checkOutput("queue7", 3'b000, 3'b000, 3'b001);
        applyStimulus(1'b1, 1'b0, 3'b000, 16'd0);
        tick(1);
        checkOutput("apply7_strobe", 3'b001, 3'b001, 3'b000);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            checkOutput($sformatf("period7_gap%0d", k), 3'b000, 3'b001, 3'b000);
        end
        tick(1);
        checkOutput("period7_strobe", 3'b001, 3'b000, 3'b000);

        // 3: write coincident with terminal count bypasses the queue
        $display("[TB] write on terminal count");
        applyStimulus(1'b0, 1'b0, 3'b001, 16'd4);
        tick(1);
        checkOutput("idle_load4", 3'b000, 3'b000, 3'b000);
        applyStimulus(1'b1, 1'b0, 3'b000, 16'd0);
        tick(3);
        checkOutput("cnt3", 3'b000, 3'b000, 3'b000);
        applyStimulus(1'b1, 1'b0, 3'b001, 16'd6);
        tick(1);
        checkOutput("bypass_strobe", 3'b001, 3'b001, 3'b000);
        applyStimulus(1'b1, 1'b0, 3'b000, 16'd0);
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            checkOutput($sformatf("period6_gap%0d", k), 3'b000, 3'b001, 3'b000);
        end
        tick(1);
        checkOutput("period6_strobe", 3'b001, 3'b000, 3'b000);

        // 4: divisor 0 disables, divisor 1 strobes every cycle
        $display("[TB] divisor 0 and divisor 1");
        applyStimulus(1'b0, 1'b0, 3'b111, 16'd0);
        tick(1);
        checkOutput("disable_all", 3'b000, 3'b000, 3'b000);
        applyStimulus(1'b1, 1'b0, 3'b000, 16'd0);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            checkOutput($sformatf("disabled%0d", k), 3'b000, 3'b000, 3'b000);
        end
        applyStimulus(1'b1, 1'b0, 3'b100, 16'd1);
        tick(1);
        checkOutput("load_div1", 3'b000, 3'b000, 3'b000);
        applyStimulus(1'b1, 1'b0, 3'b000, 16'd0);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            checkOutput($sformatf("div1_%0d", k), 3'b100,
                        (k % 2 == 0) ? 3'b100 : 3'b000, 3'b000);
        end

        // 5: sync aligns channels and applies a queued divisor
        $display("[TB] phase alignment");
        applyStimulus(1'b0, 1'b0, 3'b100, 16'd0);
        tick(1);
        checkOutput("ch2_off", 3'b000, 3'b000, 3'b000);
        applyStimulus(1'b0, 1'b0, 3'b001, 16'd3);
        tick(1);
        applyStimulus(1'b1, 1'b0, 3'b000, 16'd0);
        tick(1);
        checkOutput("skew_e1", 3'b000, 3'b000, 3'b000);
        applyStimulus(1'b1, 1'b0, 3'b010, 16'd2);
        tick(1);
        checkOutput("skew_e2", 3'b000, 3'b000, 3'b000);
        applyStimulus(1'b1, 1'b0, 3'b010, 16'd3);
        tick(1);
        checkOutput("skew_e3", 3'b001, 3'b001, 3'b010);
        applyStimulus(1'b1, 1'b1, 3'b000, 16'd0);
        tick(1);
        checkOutput("sync", 3'b000, 3'b000, 3'b000);
        applyStimulus(1'b1, 1'b0, 3'b000, 16'd0);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            checkOutput($sformatf("aligned%0d", k),
                        (k % 3 == 0) ? 3'b011 : 3'b000,
                        (k >= 3 && k < 6) ? 3'b011 : 3'b000,
                        3'b000);
        end

        // 6: pausing run holds the count and the square wave
        $display("[TB] run pause and resume");
        applyStimulus(1'b0, 1'b0, 3'b011, 16'd5);
        tick(1);
        checkOutput("load5", 3'b000, 3'b000, 3'b000);
        applyStimulus(1'b1, 1'b0, 3'b000, 16'd0);
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            checkOutput($sformatf("div5_%0d", k),
                        (k == 5) ? 3'b011 : 3'b000,
                        (k == 5) ? 3'b011 : 3'b000,
                        3'b000);
        end
        tick(2);
        checkOutput("before_pause", 3'b000, 3'b011, 3'b000);
        applyStimulus(1'b0, 1'b0, 3'b000, 16'd0);
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            checkOutput($sformatf("paused%0d", k), 3'b000, 3'b011, 3'b000);
        end
        applyStimulus(1'b1, 1'b0, 3'b000, 16'd0);
        tick(1);
        checkOutput("resume1", 3'b000, 3'b011, 3'b000);
        tick(1);
        checkOutput("resume2", 3'b000, 3'b011, 3'b000);
        tick(1);
        checkOutput("resume3", 3'b011, 3'b000, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
- Parametrised multi-channel clock-enable generator; the successor to the per-domain clock dividers.
- Runs entirely on one system clock and emits N independent single-cycle enable strobes plus 50% square waves.
- CPU core, PC/ROM stepping and LED blink logic qualify on these strobes instead of consuming derived clocks.
- Divisors are runtime-loadable, with glitch-free changeover at the next terminal count, and all channels can be phase-aligned.

Parameters:
- CHANNELS, 3, number of independent enable channels.
- DIV_WIDTH, 16, width of each divisor and counter; max divisor 2^DIV_WIDTH-1.
- RESET_DIV, 2, divisor loaded into every channel at reset.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  global count enable.
- sync  in  1  phase-align pulse for all channels.
- div_wr  in  CHANNELS  per-channel divisor write strobe.
- div_data  in  DIV_WIDTH  divisor value, shared by all write strobes.
- ce  out  CHANNELS  registered one-cycle enable strobes.
- sq  out  CHANNELS  registered square waves, toggling on each ce.
- pending  out  CHANNELS  channel has a divisor queued, not yet applied.

Behaviour:
- Per-channel state: div (DIV_WIDTH), cnt (DIV_WIDTH), pend_val (DIV_WIDTH), pending (1).
- Reset (rst=0, asynchronous): div=RESET_DIV; cnt=0; ce=0; sq=0; pending=0; pend_val=0. Takes effect mid-operation with no completion of in-flight strobes.
- Priority per edge: sync > divisor write handling > run/count.
- Counting (run=1, div!=0, sync=0):
  - If cnt==div-1: cnt<=0; ce<=1; sq<=~sq; if pending then div<=pend_val and pending<=0.
  - Otherwise: cnt<=cnt+1; ce<=0.
- Result: ce is high exactly 1 cycle in every div cycles; sq period is 2*div. The first ce comes on the div-th edge after run rises from reset state.
- div==1: ce is high every cycle while run=1; sq toggles every cycle.
- div==0: channel is disabled. ce=0, cnt held 0, sq forced 0.
- run=0: cnt and sq hold; ce<=0. Resuming continues from the held cnt.
- Divisor write (div_wr[i]=1):
  - Channel counting (run=1, div!=0): pend_val<=div_data; pending<=1. Applied at the next terminal count. The strobe at that terminal count still uses the old period.
  - Write in the same cycle as the terminal count: div_data bypasses the queue. div<=div_data directly, pending<=0, ce still pulses this cycle.
  - Channel idle (run=0 or div==0): div<=div_data immediately; cnt<=0; pending<=0.
  - Repeated writes while pending overwrite pend_val; the last one wins.
  - Multiple div_wr bits set: every selected channel takes the same div_data.
- sync=1, all channels:
  - cnt<=0; ce<=0; sq<=0.
  - Any pending divisor is applied now (div<=pend_val, pending<=0).
  - A div_wr in the same cycle loads div_data directly.
  - After sync with run=1, channels with equal divisors strobe on the same edge, the div-th edge after sync.
- Arithmetic: cnt is unsigned DIV_WIDTH with no wrap beyond div-1. Writing a divisor smaller than the current cnt only matters via the queue, so the counter never overruns.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan (CHANNELS=3, RESET_DIV=2 unless noted):
1. Reset release, run=1 -> ce[0..2] pulse on edges 2,4,6,…; sq toggles each pulse (period 4 cycles); pending=000; hold rst=0 mid-count -> all outputs 0 immediately.
2. Ch0 counting at div=4; write 3 at cnt=1 -> pending[0]=1; next ce at cnt==3 (old period 4), then period 3 and pending[0]=0. Write 5 then 7 before terminal -> period 7 applied.
3. Write coincident with terminal count (div=4, cnt=3, div_data=6) -> ce pulses this cycle; next ce 6 cycles later; pending stays 0.
4. div_wr=111, div_data=0 while run=0, then run=1 -> ce=000 and sq=000 indefinitely. Write 1 to ch2 -> ce[2] high every cycle.
5. Ch0 div=3, ch1 div=3 out of phase; pulse sync one cycle -> ce, sq, cnt cleared; both ce pulse together 3 edges later and stay aligned. A queued divisor on ch1 is applied at sync.
6. run=1 at div=5 for 2 cycles, then run=0 for 10 cycles, then run=1 -> no ce during the pause; next ce 3 cycles after resume; sq unchanged across the pause.
